// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage sitting directly upstream of the single-cycle
// Processor. It holds the PC and a writable instruction memory. Each cycle it
// fetches one 32-bit word and presents it split into op/rs/rt/rd/shamt/funct.
// It also handles stall, redirect with a one-cycle bubble, a halt opcode
// (6'h3F), out-of-range fetch detection and start/restart.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        leave IDLE/HALT and begin fetching at RESET_PC
//   stall        hold PC and all fetch outputs
//   redirect     load PC from redirect_pc (inserts one bubble)
//   redirect_pc  redirect target; low two bits ignored
//   imem_we      instruction memory write enable
//   imem_waddr   word address for writes
//   imem_wdata   word to write
//   op/rs/rt/rd/shamt/funct  fields of the fetched instruction
//   instr_valid  fields hold a real instruction this cycle
//   pc_out       byte address of the instruction on the field outputs
//   halted       high while in HALT
//   fetch_err    sticky flag: a fetch was attempted past IMEM_DEPTH
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                  IMEM_DEPTH = 64,
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          stall,
    input  logic                          redirect,
    input  logic [PC_WIDTH-1:0]           redirect_pc,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic [5:0]                    op,
    output logic [4:0]                    rs,
    output logic [4:0]                    rt,
    output logic [4:0]                    rd,
    output logic [4:0]                    shamt,
    output logic [5:0]                    funct,
    output logic                          instr_valid,
    output logic [PC_WIDTH-1:0]           pc_out,
    output logic                          halted,
    output logic                          fetch_err
);

    localparam int         AW      = $clog2(IMEM_DEPTH);
    localparam logic [5:0] HALT_OP = 6'h3F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic                valid_q, valid_d;
    logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
    logic                halted_q, halted_d;
    logic                err_q, err_d;

    logic [31:0]         imem [IMEM_DEPTH];
    logic [31:0]         fetch_word;
    logic                in_range;

    // -------------------------------------------------------------------------
    // Instruction memory
    // -------------------------------------------------------------------------
    // NOTE: the memory array has no reset; clearing every word would turn it
    // into a large bank of flops instead of a RAM, and software loads it anyway.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    // The read is taken from the array as it stands before this edge's write,
    // which gives read-before-write when fetch and write hit the same word.
    assign fetch_word = imem[pc_q[AW+1:2]];

    // Word index must lie inside the memory; any higher PC bit set is a miss.
    assign in_range   = (pc_q >> 2) < PC_WIDTH'(IMEM_DEPTH);

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the values that existed before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            pc_out_q <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            pc_out_q <= pc_out_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a hold value first so no path through the case
    // statement leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        pc_out_d = pc_out_q;
        halted_d = halted_q;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = RESET_PC;
                end
            end

            S_HALT: begin
                // stall and redirect are deliberately ignored while halted
                if (start) begin
                    state_d  = S_RUN;
                    pc_d     = RESET_PC;
                    halted_d = 1'b0;
                end
            end

            S_RUN: begin
                if (redirect) begin
                    // Redirect wins over stall and always emits a bubble.
                    pc_d    = redirect_pc & ~PC_WIDTH'(3);
                    instr_d = '0;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    if (!in_range || fetch_word[31:26] == HALT_OP) begin
                        // Halt word is swallowed; PC stays parked on it.
                        instr_d  = '0;
                        valid_d  = 1'b0;
                        pc_out_d = pc_q;
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        if (!in_range) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        instr_d  = fetch_word;
                        valid_d  = 1'b1;
                        pc_out_d = pc_q;
                        pc_d     = pc_q + PC_WIDTH'(4);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign op          = instr_q[31:26];
    assign rs          = instr_q[25:21];
    assign rt          = instr_q[20:16];
    assign rd          = instr_q[15:11];
    assign shamt       = instr_q[10:6];
    assign funct       = instr_q[5:0];
    assign instr_valid = valid_q;
    assign pc_out      = pc_out_q;
    assign halted      = halted_q;
    assign fetch_err   = err_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage directly upstream of the single-cycle Processor. Holds the PC and a writable instruction memory. Each cycle it fetches one 32-bit word and splits it into op/rs/rt/rd/shamt/funct, which drive the Processor's matching inputs. Supports stall, branch/jump redirect with a one-cycle bubble, a halt opcode and a start/restart control.

Parameters:
IMEM_DEPTH, 64, number of 32-bit words in instruction memory (power of 2)
PC_WIDTH, 32, width of the byte-addressed PC
RESET_PC, 0, PC value after reset and after start; must be word-aligned

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE/HALT and begin fetching at RESET_PC
stall  in  1  hold PC and all fetch outputs
redirect  in  1  load PC from redirect_pc (taken branch/jump)
redirect_pc  in  PC_WIDTH  redirect target; bits [1:0] forced to 0
imem_we  in  1  instruction memory write enable
imem_waddr  in  log2(IMEM_DEPTH)  word address for writes
imem_wdata  in  32  word to write
op  out  6  instr[31:26]
rs  out  5  instr[25:21]
rt  out  5  instr[20:16]
rd  out  5  instr[15:11]
shamt  out  5  instr[10:6]
funct  out  6  instr[5:0]
instr_valid  out  1  fields hold a real instruction this cycle
pc_out  out  PC_WIDTH  byte address of the instruction on the field outputs
halted  out  1  high while in HALT
fetch_err  out  1  sticky: fetch attempted past IMEM_DEPTH

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, PC=RESET_PC, all field outputs 0, instr_valid=0, pc_out=0, halted=0, fetch_err=0. Instruction memory contents are not reset.
- States: IDLE, RUN, HALT.
- IDLE: outputs held at reset values. start=1 moves to RUN with PC=RESET_PC. First fetch occurs on the following edge.
- RUN, per edge, priority: redirect > stall > normal fetch.
  - redirect=1: PC<=redirect_pc&~3; instr_valid<=0; fields<=0. This is a one-cycle bubble and applies even when stall=1.
  - stall=1 (no redirect): PC, fields, pc_out, instr_valid all hold.
  - Normal fetch: word=imem[PC[log2(IMEM_DEPTH)+1:2]]; fields<=word slices; pc_out<=PC; instr_valid<=1; PC<=PC+4. PC wraps modulo 2^PC_WIDTH.
- Latency: PC to fields is 1 cycle (registered outputs). Back-to-back fetch runs at one instruction per cycle.
- Halt opcode 6'h3F fetched: the halt word is not emitted. instr_valid<=0, fields<=0, pc_out<=PC, state<=HALT, halted<=1. PC stays at the halt address.
- Out of range (PC>>2 >= IMEM_DEPTH at a normal fetch): treated as halt, and fetch_err<=1. fetch_err clears only on reset.
- HALT: redirect and stall are ignored. start=1 moves to RUN, PC=RESET_PC, halted<=0.
- start=1 while in RUN is ignored.
- Instruction memory write: on an edge with imem_we=1, imem[imem_waddr]<=imem_wdata, in any state. A fetch of the same word on the same edge returns the old contents (read-before-write).
- Opcode encodings consumed downstream are 6'h01 add, 6'h02 sw, 6'h04 lw. This block passes them through unmodified and decodes only 6'h3F.
- Reset asserted mid-RUN: the block returns to IDLE immediately. Any in-flight field outputs are cleared asynchronously.

Test Plan:
- Load imem[0]=0x00430800 (op 0x00 rs2 rt3 rd1), imem[1]=0x3C000000 (op 0x0F). start=1. Required: after 1 edge PC=0 with fields unchanged; next edge rs=2, rt=3, rd=1, instr_valid=1, pc_out=0; then pc_out=4, op=0x0F.
- Load imem[0..2] with op 0x01/0x02/0x04, then imem[3]=0xFC000000 (halt). Run. Required: valid ops on three consecutive cycles, then instr_valid=0, halted=1, PC=12, and outputs stay frozen for 5 further cycles.
- Raise stall for 3 cycles mid-stream. Required: op, pc_out and instr_valid unchanged for 3 cycles, then resumption at the next sequential address.
- Raise redirect=1 with redirect_pc=0x0000000B and stall=1 in the same cycle. Required: one bubble (instr_valid=0), then pc_out=0x8 with fields from imem[2].
- IMEM_DEPTH=4, no halt word in memory. Required: after pc_out=12 the next fetch sets fetch_err=1 and halted=1. Pulse rst_n=0 mid-run: all outputs read 0 immediately, before the next clock edge.
